control_unit_mc: RTL and testbench

//   Parametrised multi-cycle control FSM for the 16-bit processor: decodes opcode/reg_s/acc_s/flags into one-hot datapath strobes.

---
 rtl/control_unit_mc.sv | 146 ++++++++++++++
 tb/tb_control_unit_mc.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/control_unit_mc.sv
// Multi-cycle control FSM for the 16-bit processor: opcode decode into one-hot datapath strobes,
// with memory-stall hold, hazard stall and a timed ALU handshake. Optional interrupt entry under CU_IRQ_EN.
module control_unit_mc #(
  parameter int OPCODE_W    = 6,
  parameter int FLAG_W      = 4,
  parameter int ALU_TIMEOUT = 16,
  parameter int STATE_W     = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                reg_s,
  input  logic                acc_s,
  input  logic [FLAG_W-1:0]   flags,
  input  logic                hazard,
  input  logic                mem_stall,
  input  logic                alu_ready,
`ifdef CU_IRQ_EN
  input  logic                irq,
  output logic                irq_ack,
`endif
  output logic                move,
  output logic                store,
  output logic                branch,
  output logic                pop,
  output logic                push,
  output logic                stall,
  output logic                str_rez,
  output logic                load_y,
  output logic                load_x,
  output logic                acc_opx,
  output logic                acc_opy,
  output logic                done,
  output logic                reset_cu,
  output logic                error,
  output logic [STATE_W-1:0]  state
);

  typedef enum logic [4:0] {
    IDLE = 5'd0, LOAD_Y = 5'd1, LOAD_X = 5'd2, STORE = 5'd3, BRANCH = 5'd4,
    ALU = 5'd5, MOV_Y = 5'd6, ACC_Y = 5'd7, MOV_X = 5'd8, ACC_X = 5'd9,
    PUSH = 5'd10, POP_Y = 5'd11, POP_X = 5'd12, DONE = 5'd13, NOP = 5'd14,
    STALL = 5'd15, ALU_WAIT = 5'd16, ERROR = 5'd17, IRQ = 5'd18
  } st_e;

  localparam int CNT_W = (ALU_TIMEOUT > 2) ? $clog2(ALU_TIMEOUT) : 1;

  st_e              cur, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             decide, mem_st;

  function automatic st_e decode(input logic [OPCODE_W-1:0] op, input logic rs, input logic as,
                                 input logic [FLAG_W-1:0] fl);
    int unsigned v;
    v = 32'(op);
    decode = rs ? POP_Y : POP_X;
    if (op == {OPCODE_W{1'b1}}) decode = NOP;
    case (v)
      32'h00:                                       decode = DONE;
      32'h01:                                       decode = rs ? LOAD_Y : LOAD_X;
      32'h02:                                       decode = STORE;
      32'h03, 32'h04, 32'h05, 32'h06:               decode = NOP;
      32'h07:                                       decode = BRANCH;
      32'h08, 32'h09, 32'h18, 32'h19:               decode = NOP;
      32'h0A, 32'h0B, 32'h0C, 32'h0D, 32'h0E, 32'h0F,
      32'h11, 32'h12, 32'h13, 32'h14, 32'h15,
      32'h1A, 32'h1B:                               decode = ALU;
      32'h16, 32'h17:                               decode = ALU_WAIT;
      32'h10: case ({rs, as})
                2'b11:   decode = ACC_Y;
                2'b10:   decode = MOV_Y;
                2'b01:   decode = ACC_X;
                default: decode = MOV_X;
              endcase
      32'h1C:                                       decode = PUSH;
      default: ;
    endcase
    // conditional branches only exist for implemented flag bits; the rest fall through as NOP
    for (int i = 0; i < FLAG_W; i++)
      if (v == 32'(3 + i)) decode = fl[i] ? BRANCH : NOP;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= IDLE;
      cnt <= '0;
    end else begin
      cur <= nxt;
      cnt <= cnt_nxt;
    end
  end

  assign mem_st = (cur inside {LOAD_Y, LOAD_X, STORE, PUSH, POP_Y, POP_X});

  always_comb begin
    nxt     = cur;
    cnt_nxt = cnt;
    decide  = 1'b0;
    if (cur == IDLE)             decide = start;
    else if (cur == DONE)        nxt = IDLE;
    else if (cur == ERROR)       nxt = ERROR;
    else if (mem_st && mem_stall) nxt = cur;
    else if (cur == ALU_WAIT) begin
      if (alu_ready)                           decide = 1'b1;
      else if (cnt == CNT_W'(ALU_TIMEOUT - 1)) nxt = ERROR;
      else                                     cnt_nxt = cnt + 1'b1;
    end else                     decide = 1'b1;

    if (decide) begin
      if (hazard) nxt = STALL;
`ifdef CU_IRQ_EN
      else if (irq && cur != IDLE) nxt = IRQ;
`endif
      else begin
        nxt = decode(opcode, reg_s, acc_s, flags);
        if (nxt == ALU_WAIT) cnt_nxt = '0;
      end
    end
  end

  always_comb begin
    reset_cu = (cur == IDLE);
    move     = (cur == MOV_Y) || (cur == MOV_X);
    store    = (cur == STORE) || (cur == PUSH);
    branch   = (cur == BRANCH) || (cur == IRQ);
    push     = (cur == PUSH) || (cur == IRQ);
    pop      = (cur == POP_Y) || (cur == POP_X);
    load_y   = (cur == LOAD_Y) || (cur == POP_Y);
    load_x   = (cur == LOAD_X) || (cur == POP_X);
    acc_opy  = (cur == MOV_Y) || (cur == ACC_Y);
    acc_opx  = (cur == MOV_X) || (cur == ACC_X);
    done     = (cur == DONE);
    error    = (cur == ERROR);
    // result strobe in ALU_WAIT follows alu_ready combinationally
    str_rez  = (cur == ALU) || (cur == MOV_Y) || (cur == MOV_X) || ((cur == ALU_WAIT) && alu_ready);
    stall    = (cur == STALL) || (cur == ALU_WAIT) || (mem_st && mem_stall);
  end

`ifdef CU_IRQ_EN
  assign irq_ack = (cur == IRQ);
`endif

  assign state = STATE_W'(cur);

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed-vector bench for control_unit_mc; strobes are packed into one vector and compared per step.
module tb_control_unit_mc;
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [5:0] opcode = '0;
  logic       reg_s = 1'b0, acc_s = 1'b0, hazard = 1'b0, mem_stall = 1'b0, alu_ready = 1'b0;
  logic [3:0] flags = '0;
  logic       move, store, branch, pop, push, stall, str_rez, load_y, load_x;
  logic       acc_opx, acc_opy, done, reset_cu, error;
  logic [4:0] state;
`ifdef CU_IRQ_EN
  logic       irq = 1'b0, irq_ack;
`endif

  int total = 0, passed = 0;

  localparam logic [13:0] M_MOVE = 14'h2000, M_STORE = 14'h1000, M_BR = 14'h0800, M_POP = 14'h0400,
                          M_PUSH = 14'h0200, M_STALL = 14'h0100, M_REZ = 14'h0080, M_LDY = 14'h0040,
                          M_LDX = 14'h0020, M_AOX = 14'h0010, M_AOY = 14'h0008, M_DONE = 14'h0004,
                          M_RCU = 14'h0002, M_ERR = 14'h0001;

  control_unit_mc #(.OPCODE_W(6), .FLAG_W(4), .ALU_TIMEOUT(16), .STATE_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .reg_s(reg_s), .acc_s(acc_s),
    .flags(flags), .hazard(hazard), .mem_stall(mem_stall), .alu_ready(alu_ready),
`ifdef CU_IRQ_EN
    .irq(irq), .irq_ack(irq_ack),
`endif
    .move(move), .store(store), .branch(branch), .pop(pop), .push(push), .stall(stall),
    .str_rez(str_rez), .load_y(load_y), .load_x(load_x), .acc_opx(acc_opx), .acc_opy(acc_opy),
    .done(done), .reset_cu(reset_cu), .error(error), .state(state));

  always #5 clk = ~clk;

  function automatic logic [13:0] strobes();
    return {move, store, branch, pop, push, stall, str_rez, load_y, load_x,
            acc_opx, acc_opy, done, reset_cu, error};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] exp_st, input logic [13:0] exp_sb);
    logic [13:0] sb;
    sb = strobes();
    total++;
    assert (state === exp_st) passed++;
    else $error("FAIL %s state: got %0d expected %0d", tag, state, exp_st);
    total++;
    assert (sb === exp_sb) passed++;
    else $error("FAIL %s strobes: got %h expected %h", tag, sb, exp_sb);
  endtask

  initial begin
    // reset and idle
    repeat (2) tick();
    reset = 1'b0;
    repeat (10) tick();
    chk("idle", 5'd0, M_RCU);

    // LOAD_Y held by mem_stall for 4 cycles
    opcode = 6'h01; reg_s = 1'b1; mem_stall = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk("ldy_c1", 5'd1, M_LDY | M_STALL);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("ldy_held", 5'd1, M_LDY | M_STALL);
    end
    tick(); mem_stall = 1'b0; #1;
    chk("ldy_c4", 5'd1, M_LDY);

    // conditional branch on flags[2], then not taken
    opcode = 6'h05; flags = 4'b0100;
    tick(); chk("br_taken", 5'd4, M_BR);
    flags = 4'b0000;
    tick(); chk("br_not", 5'd14, 14'h0);
    opcode = 6'h03; flags = 4'b0001;
    tick(); chk("br_f0", 5'd4, M_BR);

    // ALU_WAIT, ready arrives in 6th cycle
    opcode = 6'h16;
    tick(); chk("aw_c1", 5'd16, M_STALL);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("aw_wait", 5'd16, M_STALL);
    end
    tick(); alu_ready = 1'b1; #1;
    chk("aw_ready", 5'd16, M_STALL | M_REZ);

    // 0x10 register/accumulator moves
    opcode = 6'h10; reg_s = 1'b1; acc_s = 1'b1;
    tick(); alu_ready = 1'b0; #1;
    chk("acc_y", 5'd7, M_AOY);
    acc_s = 1'b0;
    tick(); chk("mov_y", 5'd6, M_MOVE | M_AOY | M_REZ);
    reg_s = 1'b0; acc_s = 1'b1;
    tick(); chk("acc_x", 5'd9, M_AOX);
    acc_s = 1'b0;
    tick(); chk("mov_x", 5'd8, M_MOVE | M_AOX | M_REZ);

    hazard = 1'b1;
    tick(); chk("hazard", 5'd15, M_STALL);
    hazard = 1'b0;

    opcode = 6'h0A;
    tick(); chk("alu", 5'd5, M_REZ);
`ifdef CU_IRQ_EN
    irq = 1'b1;
    tick(); chk("irq", 5'd18, M_PUSH | M_BR);
    total++;
    assert (irq_ack === 1'b1) passed++;
    else $error("FAIL irq_ack: got %b expected 1", irq_ack);
    irq = 1'b0;
`endif
    opcode = 6'h1C;
    tick(); chk("push", 5'd10, M_STORE | M_PUSH);
    opcode = 6'h02;
    tick(); chk("store", 5'd3, M_STORE);
    opcode = 6'h20;
    tick(); chk("pop_x", 5'd12, M_POP | M_LDX);
    opcode = 6'h3F;
    tick(); chk("all_ones", 5'd14, 14'h0);
    opcode = 6'h07;
    tick(); chk("br_uncond", 5'd4, M_BR);
    opcode = 6'h00;
    tick(); chk("done", 5'd13, M_DONE);
    tick(); chk("back_idle", 5'd0, M_RCU);

    // ALU timeout: 16 cycles in ALU_WAIT, then sticky ERROR
    opcode = 6'h17; start = 1'b1;
    tick(); start = 1'b0;
    chk("to_c1", 5'd16, M_STALL);
    repeat (15) tick();
    chk("to_c16", 5'd16, M_STALL);
    tick(); chk("error", 5'd17, M_ERR);
    repeat (3) tick();
    chk("error_sticky", 5'd17, M_ERR);

    // async reset between clock edges
    #2 reset = 1'b1; #1;
    chk("async_rst", 5'd0, M_RCU);
    tick(); reset = 1'b0;

    // mem_stall hold beats hazard; hazard taken at next decision point
    opcode = 6'h01; reg_s = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    chk("ldx", 5'd2, M_LDX);
    mem_stall = 1'b1; hazard = 1'b1;
    tick(); chk("ms_vs_hz", 5'd2, M_LDX | M_STALL);
    mem_stall = 1'b0;
    tick(); chk("hz_after", 5'd15, M_STALL);
    hazard = 1'b0;

    // reset asserted inside ALU_WAIT
    opcode = 6'h16;
    tick(); chk("aw_again", 5'd16, M_STALL);
    #2 reset = 1'b1; #1;
    chk("rst_in_aw", 5'd0, M_RCU);
    tick(); reset = 1'b0;
    tick(); chk("idle_after", 5'd0, M_RCU);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
